// File: rtl/lvds_tx_framer_pkg.sv
// rtl/lvds_tx_framer_pkg.sv - K-symbol constants, FSM state encoding and CRC-8 byte step for lvds_tx_framer
package lvds_tx_framer_pkg;

    localparam logic [7:0] K_IDLE = 8'hBC;  // K28.5
    localparam logic [7:0] K_SOP  = 8'hFB;  // K27.7
    localparam logic [7:0] K_EOP  = 8'hFD;  // K29.7
    localparam logic [7:0] K_FILL = 8'h1C;  // K28.0

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_SOP  = 3'd1;
    localparam state_t ST_DATA = 3'd2;
    localparam state_t ST_CRC  = 3'd3;
    localparam state_t ST_EOP  = 3'd4;
    localparam state_t ST_DROP = 3'd5;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    // MSB-first, non-reflected: fold the whole byte in, then shift it out.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/crc8_step.sv
// rtl/crc8_step.sv - combinational CRC-8 (poly 0x07) single-byte update
module crc8_step
    import lvds_tx_framer_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] data_in,
    output logic [7:0] crc_out
);

    assign crc_out = crc8_byte(crc_in, data_in);

endmodule

// File: rtl/lvds_tx_framer.sv
// rtl/lvds_tx_framer.sv - byte-stream to K-symbol framer feeding an 8B/10B encoder
// Optional CRC-8 trailer before EOP when LVDS_TX_FRAMER_CRC8_EN is defined.
module lvds_tx_framer
    import lvds_tx_framer_pkg::*;
#(
    parameter int MAX_LEN  = 256,
    parameter int IDLE_MIN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [7:0]  enc_data,
    output logic        enc_kin,
    output logic [15:0] frame_cnt,
    output logic        err_overlen
);

    localparam logic [15:0] LP_LAST_IDX = 16'(MAX_LEN - 1);
    localparam logic [3:0]  LP_IDLE_MIN = 4'(IDLE_MIN);
`ifdef LVDS_TX_FRAMER_CRC8_EN
    localparam state_t      LP_END_ST   = ST_CRC;
`else
    localparam state_t      LP_END_ST   = ST_EOP;
`endif

    state_t      r_state;
    logic [3:0]  r_gap;
    logic [15:0] r_byte_cnt;
    logic        r_trunc;
    logic [7:0]  r_enc_data;
    logic        r_enc_kin;
    logic [15:0] r_frame_cnt;
    logic        r_err;

    logic        w_hs;
    logic [3:0]  w_gap_inc;

    assign s_ready     = (r_state == ST_DATA) || (r_state == ST_DROP);
    assign w_hs        = s_valid && s_ready;
    // Gap includes the IDLE being emitted this cycle, so SOP follows exactly IDLE_MIN IDLEs.
    assign w_gap_inc   = (r_gap == 4'hF) ? 4'hF : r_gap + 4'd1;

    assign enc_data    = r_enc_data;
    assign enc_kin     = r_enc_kin;
    assign frame_cnt   = r_frame_cnt;
    assign err_overlen = r_err;

`ifdef LVDS_TX_FRAMER_CRC8_EN
    logic [7:0] r_crc;
    logic [7:0] w_crc_nxt;

    crc8_step u_crc8_step (
        .crc_in  (r_crc),
        .data_in (s_data),
        .crc_out (w_crc_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_crc <= 8'h00;
        end else if (r_state == ST_SOP) begin
            r_crc <= 8'h00;
        end else if ((r_state == ST_DATA) && w_hs) begin
            r_crc <= w_crc_nxt;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_gap       <= 4'd0;
            r_byte_cnt  <= 16'd0;
            r_trunc     <= 1'b0;
            r_enc_data  <= K_IDLE;
            r_enc_kin   <= 1'b1;
            r_frame_cnt <= 16'd0;
            r_err       <= 1'b0;
        end else begin
            r_err      <= 1'b0;
            r_enc_data <= K_IDLE;
            r_enc_kin  <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    r_gap <= w_gap_inc;
                    if (s_valid && (w_gap_inc >= LP_IDLE_MIN)) begin
                        r_state <= ST_SOP;
                    end
                end
                ST_SOP: begin
                    r_enc_data <= K_SOP;
                    r_byte_cnt <= 16'd0;
                    r_state    <= ST_DATA;
                end
                ST_DATA: begin
                    if (w_hs) begin
                        r_enc_data <= s_data;
                        r_enc_kin  <= 1'b0;
                        r_byte_cnt <= r_byte_cnt + 16'd1;
                        if (s_last) begin
                            r_state <= LP_END_ST;
                        end else if (r_byte_cnt == LP_LAST_IDX) begin
                            r_state <= LP_END_ST;
                            r_trunc <= 1'b1;
                        end
                    end else begin
                        r_enc_data <= K_FILL;
                    end
                end
`ifdef LVDS_TX_FRAMER_CRC8_EN
                ST_CRC: begin
                    r_enc_data <= r_crc;
                    r_enc_kin  <= 1'b0;
                    r_state    <= ST_EOP;
                end
`endif
                ST_EOP: begin
                    r_enc_data  <= K_EOP;
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                    r_gap       <= 4'd0;
                    r_err       <= r_trunc;
                    r_trunc     <= 1'b0;
                    r_state     <= r_trunc ? ST_DROP : ST_IDLE;
                end
                ST_DROP: begin
                    r_gap <= w_gap_inc;
                    if (w_hs && s_last) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lvds_tx_framer.sv
// tb/tb_lvds_tx_framer.sv - scoreboard bench for lvds_tx_framer (CRC trailer follows LVDS_TX_FRAMER_CRC8_EN)
module tb_lvds_tx_framer;

    localparam int TB_MAX_LEN  = 9;
    localparam int TB_IDLE_MIN = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic [7:0]  enc_data;
    logic        enc_kin;
    logic [15:0] frame_cnt;
    logic        err_overlen;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [9:0]  sb[$];
    logic [7:0]  frm[$];
    int          idle_run = 0;
    bit          exact_gap = 1'b0;
    int          err_pulses = 0;

    lvds_tx_framer #(.MAX_LEN(TB_MAX_LEN), .IDLE_MIN(TB_IDLE_MIN)) dut (
        .clk         (clk),
        .rst         (rst),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .enc_data    (enc_data),
        .enc_kin     (enc_kin),
        .frame_cnt   (frame_cnt),
        .err_overlen (err_overlen)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

`ifdef LVDS_TX_FRAMER_CRC8_EN
    function automatic logic [7:0] tb_crc(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        logic       fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[7] ^ d[i];
            r  = {r[6:0], 1'b0};
            if (fb) r = r ^ 8'h07;
        end
        return r;
    endfunction
`endif

    always @(negedge clk) begin
        if (rst) begin
            idle_run = 0;
        end else begin
            if (err_overlen) err_pulses++;
            if (enc_kin && (enc_data == 8'hBC)) begin
                idle_run++;
            end else begin
                if (enc_kin && (enc_data == 8'hFB)) begin
                    if (exact_gap) begin
                        chk("gap_exact", 32'(idle_run), 32'(TB_IDLE_MIN));
                        exact_gap = 1'b0;
                    end else begin
                        chk("gap_min", 32'((idle_run >= TB_IDLE_MIN) ? TB_IDLE_MIN : idle_run), 32'(TB_IDLE_MIN));
                    end
                end
                idle_run = 0;
                if (sb.size() == 0)
                    chk("sym_unexpected", 32'({err_overlen, enc_kin, enc_data}), 32'h3FF);
                else
                    chk("sym", 32'({err_overlen, enc_kin, enc_data}), 32'(sb.pop_front()));
            end
        end
    end

    task automatic put_byte(input logic [7:0] d, input logic last, output bit ok);
        bit hs;
        s_data  = d;
        s_last  = last;
        s_valid = 1'b1;
        ok      = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            hs = s_ready;
            @(posedge clk);
            #1;
            ok = hs;
        end
        if (!ok) chk("hs_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_frame(input int stall_after, input int stall_len, input bit keep_valid);
        int n;
        bit ok;
`ifdef LVDS_TX_FRAMER_CRC8_EN
        logic [7:0] crc;
        crc = 8'h00;
`endif
        n = frm.size();
        sb.push_back({2'b01, 8'hFB});
        for (int i = 0; i < n && i < TB_MAX_LEN; i++) begin
            sb.push_back({2'b00, frm[i]});
`ifdef LVDS_TX_FRAMER_CRC8_EN
            crc = tb_crc(crc, frm[i]);
`endif
            if (i == stall_after) repeat (stall_len) sb.push_back({2'b01, 8'h1C});
        end
`ifdef LVDS_TX_FRAMER_CRC8_EN
        sb.push_back({2'b00, crc});
`endif
        sb.push_back({(n > TB_MAX_LEN), 1'b1, 8'hFD});
        for (int i = 0; i < n; i++) begin
            put_byte(frm[i], (i == n - 1), ok);
            if (!ok) return;
            if (i == stall_after && stall_len > 0) begin
                s_valid = 1'b0;
                repeat (stall_len) @(posedge clk);
                #1;
            end
        end
        if (!keep_valid) begin
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 400 && sb.size() > 0; c++) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic load_ramp(input logic [7:0] base, input int n);
        frm.delete();
        for (int i = 0; i < n; i++) frm.push_back(base + 8'(i));
    endtask

    initial begin
        bit ok;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_data",  32'(enc_data),    32'hBC);
        chk("rst_kin",   32'(enc_kin),     32'd1);
        chk("rst_ready", 32'(s_ready),     32'd0);
        chk("rst_fcnt",  32'(frame_cnt),   32'd0);
        chk("rst_err",   32'(err_overlen), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_sym",   32'({enc_kin, enc_data}), 32'h1BC);
            chk("idle_ready", 32'(s_ready),             32'd0);
        end
        chk("idle_fcnt", 32'(frame_cnt), 32'd0);

        load_ramp(8'h31, 9);
        send_frame(-1, 0, 1'b0);
        drain();
        chk("fcnt_f1", 32'(frame_cnt), 32'd1);

        load_ramp(8'h50, 5);
        send_frame(-1, 0, 1'b1);
        exact_gap = 1'b1;
        load_ramp(8'h60, 6);
        send_frame(-1, 0, 1'b0);
        drain();
        chk("fcnt_b2b", 32'(frame_cnt), 32'd3);

        frm.delete();
        frm.push_back(8'hA5);
        send_frame(-1, 0, 1'b0);
        drain();
        chk("fcnt_one", 32'(frame_cnt), 32'd4);

        load_ramp(8'h70, 8);
        send_frame(2, 3, 1'b0);
        drain();
        chk("fcnt_stall", 32'(frame_cnt), 32'd5);

        chk("err_before_trunc", 32'(err_pulses), 32'd0);
        load_ramp(8'h80, TB_MAX_LEN + 3);
        send_frame(-1, 0, 1'b0);
        drain();
        chk("err_after_trunc", 32'(err_pulses), 32'd1);
        chk("fcnt_trunc", 32'(frame_cnt), 32'd6);

        load_ramp(8'h90, 3);
        send_frame(-1, 0, 1'b0);
        drain();
        chk("fcnt_post_trunc", 32'(frame_cnt), 32'd7);

        sb.push_back({2'b01, 8'hFB});
        for (int i = 0; i < 3; i++) begin
            sb.push_back({2'b00, 8'hC0 + 8'(i)});
            put_byte(8'hC0 + 8'(i), 1'b0, ok);
        end
        rst = 1'b1;
        #1;
        chk("midrst_data",  32'(enc_data),  32'hBC);
        chk("midrst_kin",   32'(enc_kin),   32'd1);
        chk("midrst_ready", 32'(s_ready),   32'd0);
        chk("midrst_fcnt",  32'(frame_cnt), 32'd0);
        s_valid = 1'b0;
        s_last  = 1'b0;
        sb.delete();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        load_ramp(8'hD0, 4);
        send_frame(-1, 0, 1'b0);
        drain();
        chk("fcnt_post_rst", 32'(frame_cnt), 32'd1);
        repeat (5) @(negedge clk);
        chk("sb_final", 32'(sb.size()), 32'd0);
        chk("err_final", 32'(err_pulses), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
